// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one ALU (aluController + datapath) between two requesters using
//   round-robin arbitration. The accepted operation is registered onto the
//   alu_* outputs, and the ALU result is captured one cycle later. This keeps
//   the combinational ALU path isolated from requester timing. Each operation
//   runs IDLE -> EXEC -> RESP -> IDLE, so the best case is one op per 3 cycles.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_aluOp/funct3/funct7 operation select passed through to the ALU
//   reqN_a / reqN_b          operands, passed through unmodified
//   alu_aluOp..alu_b         registered ALU inputs
//   alu_result / alu_zero    combinational ALU outputs
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester that owns the response
//   rsp_result / rsp_zero    captured ALU outputs
//   busy                     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_aluOp,
  input  logic [2:0]       req0_funct3,
  input  logic             req0_funct7,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_aluOp,
  input  logic [2:0]       req1_funct3,
  input  logic             req1_funct7,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_aluOp,
  output logic [2:0]       alu_funct3,
  output logic             alu_funct7,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic             last_grant_reg;
  logic [1:0]       alu_op_reg;
  logic [2:0]       alu_f3_reg;
  logic             alu_f7_reg;
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
  logic             rsp_id_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic             rsp_zero_reg;

  logic [1:0] valid_vec;
  logic [1:0] ready_vec;
  logic       accept;
  logic       sel;

  assign valid_vec = {req1_valid, req0_valid};

  // A port wins if it is the only one asking, or if both ask and the other
  // port was granted last. Ready is masked during reset so nothing can be
  // accepted while rst is high.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic other_had_last;
      assign other_had_last = (last_grant_reg == 1'(1 - gi));
      assign ready_vec[gi]  = valid_vec[gi] & (~valid_vec[1-gi] | other_had_last)
                              & (state_reg == IDLE) & ~rst;
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;
  assign sel        = ready_vec[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;  // port 0 wins the first tie after reset
      alu_op_reg     <= '0;
      alu_f3_reg     <= '0;
      alu_f7_reg     <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        alu_op_reg     <= sel ? req1_aluOp  : req0_aluOp;
        alu_f3_reg     <= sel ? req1_funct3 : req0_funct3;
        alu_f7_reg     <= sel ? req1_funct7 : req0_funct7;
        alu_a_reg      <= sel ? req1_a      : req0_a;
        alu_b_reg      <= sel ? req1_b      : req0_b;
        rsp_id_reg     <= sel;
        last_grant_reg <= sel;
      end
      // ALU inputs have been stable for the whole EXEC cycle; capture here.
      if (state_reg == EXEC) begin
        rsp_result_reg <= alu_result;
        rsp_zero_reg   <= alu_zero;
      end
    end
  end

  assign alu_aluOp  = alu_op_reg;
  assign alu_funct3 = alu_f3_reg;
  assign alu_funct7 = alu_f7_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_funct7;
  logic [1:0]  req0_aluOp;
  logic [2:0]  req0_funct3;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_funct7;
  logic [1:0]  req1_aluOp;
  logic [2:0]  req1_funct3;
  logic [31:0] req1_a, req1_b;
  logic [1:0]  alu_aluOp;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluOp(req0_aluOp),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluOp(req1_aluOp),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_a(req1_a), .req1_b(req1_b),
    .alu_aluOp(alu_aluOp), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Behavioural stand-in for the shared ALU.
  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [2:0] f3,
                                          input logic f7, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      2'b00: return a + b;
      2'b10: return a - b;
      2'b11: return b;
      default: begin
        case (f3)
          3'b000:  return f7 ? a - b : a + b;
          3'b001:  return a << b[4:0];
          3'b100:  return a ^ b;
          3'b101:  return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'b110:  return a | b;
          3'b111:  return a & b;
          default: return 32'h0;
        endcase
      end
    endcase
  endfunction

  assign alu_result = alu_ref(alu_aluOp, alu_funct3, alu_funct7, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'h0);

  // Response monitor: pops the scoreboard on every completed response handshake.
  always @(negedge clk) begin
    #2;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d result=%h, required no response", rsp_id, rsp_result);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_id !== mon_e.id || rsp_result !== mon_e.res || rsp_zero !== mon_e.zero) begin
          bad++;
          $display("FAIL rsp_data: got id=%0d result=%h zero=%0d, required id=%0d result=%h zero=%0d",
                   rsp_id, rsp_result, rsp_zero, mon_e.id, mon_e.res, mon_e.zero);
        end else
          $display("rsp id=%0d result=%h zero=%0d ok", rsp_id, rsp_result, rsp_zero);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit port, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res);
    bit done = 1'b0;
    if (port) begin
      req1_valid = 1; req1_aluOp = op; req1_funct3 = f3; req1_funct7 = f7; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_aluOp = op; req0_funct3 = f3; req0_funct7 = f7; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        @(posedge clk);
        sb.push_back('{id: port, res: exp_res, zero: (exp_res == 32'h0)});
        $display("accept port=%0d a=%h b=%h", port, a, b);
        #1;
        if (port) req1_valid = 0; else req0_valid = 0;
        done = 1'b1;
      end else
        @(negedge clk);
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL issue_timeout: port %0d never got ready, required accept", port);
      req0_valid = 0; req1_valid = 0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1; rsp_ready = 1;
    req0_valid = 1; req0_aluOp = 2'b01; req0_funct3 = 3'b000; req0_funct7 = 0; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_aluOp = 2'b01; req1_funct3 = 3'b110; req1_funct7 = 0; req1_a = 3; req1_b = 4;
    @(negedge clk); #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b, required 00", {req0_ready, req1_ready});
    end
    total++;
    if ({busy, rsp_valid, rsp_id, rsp_zero} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: busy/rsp_valid/rsp_id/rsp_zero=%b, required 0000",
                      {busy, rsp_valid, rsp_id, rsp_zero});
    end
    total++;
    if (alu_a !== 0 || alu_b !== 0 || alu_aluOp !== 0 || alu_funct3 !== 0 || alu_funct7 !== 0 || rsp_result !== 0) begin
      bad++; $display("FAIL reset_data: alu_a=%h alu_b=%h op=%b rsp_result=%h, required all 0",
                      alu_a, alu_b, alu_aluOp, rsp_result);
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    req0_valid = 1; req0_aluOp = 2'b01; req0_funct3 = 3'b000; req0_funct7 = 0; req0_a = 5; req0_b = 7;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL single_ready: got r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    sb.push_back('{id: 1'b0, res: 32'd12, zero: 1'b0});
    $display("accept port=0 a=5 b=7");
    #1 req0_valid = 0;
    @(negedge clk); #1;
    total++;
    if (alu_aluOp !== 2'b01 || alu_funct3 !== 3'b000 || alu_funct7 !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      bad++; $display("FAIL single_latch: op=%b f3=%b f7=%b a=%h b=%h, required 01 000 0 5 7",
                      alu_aluOp, alu_funct3, alu_funct7, alu_a, alu_b);
    end
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_exec: rsp_valid=%b busy=%b, required 0 1", rsp_valid, busy);
    end
    @(negedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL single_latency: rsp_valid=%b two cycles after accept, required 1", rsp_valid);
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
    end
    wait_drain();
  endtask

  task automatic test_tie();
    logic order[2];
    int n = 0;
    bit r0, r1;
    rst = 1; @(negedge clk); rst = 0; @(negedge clk);
    req0_valid = 1; req0_aluOp = 2'b01; req0_funct3 = 3'b000; req0_funct7 = 1; req0_a = 9;     req0_b = 9;
    req1_valid = 1; req1_aluOp = 2'b01; req1_funct3 = 3'b110; req1_funct7 = 0; req1_a = 'hF0;  req1_b = 'h0F;
    for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
      #1; r0 = req0_ready; r1 = req1_ready;
      @(posedge clk);
      if (r0) begin
        order[n] = 0; n++;
        sb.push_back('{id: 1'b0, res: 32'h0, zero: 1'b1});
        $display("accept port=0 a=9 b=9 (SUB)");
        #1 req0_valid = 0;
      end else if (r1) begin
        order[n] = 1; n++;
        sb.push_back('{id: 1'b1, res: 32'hFF, zero: 1'b0});
        $display("accept port=1 a=f0 b=0f (OR)");
        #1 req1_valid = 0;
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    total++;
    if (n != 2 || order[0] !== 1'b0 || order[1] !== 1'b1) begin
      bad++; $display("FAIL tie_order: got n=%0d first=%b second=%b, required 2 grants 0 then 1",
                      n, order[0], order[1]);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic exp_port = 1'b0;
    int n = 0;
    int k = 0;
    bit r0, r1;
    logic [2:0] f3s [4] = '{3'b000, 3'b110, 3'b111, 3'b100};
    req0_valid = 1; req0_aluOp = 2'b01; req0_funct7 = 0; req0_funct3 = f3s[0]; req0_a = 32'd3;  req0_b = 32'd1;
    req1_valid = 1; req1_aluOp = 2'b01; req1_funct7 = 0; req1_funct3 = f3s[1]; req1_a = 32'd20; req1_b = 32'd6;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      #1; r0 = req0_ready; r1 = req1_ready;
      if (r0 && r1) begin
        total++; bad++;
        $display("FAIL b2b_double_grant: both ready high, required at most one");
      end
      @(posedge clk);
      if (r0 || r1) begin
        total++;
        if (r1 !== exp_port) begin
          bad++; $display("FAIL b2b_grant: op %0d went to port %0d, required port %0d", n, r1, exp_port);
        end
        if (r1)
          sb.push_back('{id: 1'b1, res: alu_ref(req1_aluOp, req1_funct3, req1_funct7, req1_a, req1_b),
                         zero: (alu_ref(req1_aluOp, req1_funct3, req1_funct7, req1_a, req1_b) == 0)});
        else
          sb.push_back('{id: 1'b0, res: alu_ref(req0_aluOp, req0_funct3, req0_funct7, req0_a, req0_b),
                         zero: (alu_ref(req0_aluOp, req0_funct3, req0_funct7, req0_a, req0_b) == 0)});
        $display("accept port=%0d op#%0d", r1, n);
        exp_port = ~exp_port;
        n++; k++;
        #1;
        if (r1) begin
          req1_funct3 = f3s[k % 4]; req1_a = 32'(k * 17 + 3); req1_b = 32'(k * 5 + 1);
        end else begin
          req0_funct3 = f3s[k % 4]; req0_a = 32'(k * 13 + 2); req0_b = 32'(k * 7 + 4);
        end
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    total++;
    if (n != 6) begin
      bad++; $display("FAIL b2b_count: got %0d grants, required 6", n);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    bit seen = 1'b0;
    rsp_ready = 0;
    issue(1'b0, 2'b01, 3'b100, 1'b0, 32'h0000_A5A5, 32'h0000_0F0F, 32'h0000_AAAA);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (rsp_valid === 1'b1);
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL stall_rsp_timeout: rsp_valid never rose, required 1");
    end
    req1_valid = 1; req1_aluOp = 2'b01; req1_funct3 = 3'b111; req1_funct7 = 0;
    req1_a = 32'hFF00_FF00; req1_b = 32'h0FF0_0FF0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h0000_AAAA || rsp_zero !== 1'b0) begin
        bad++; $display("FAIL stall_hold: cyc %0d valid=%b id=%b result=%h zero=%b, required 1 0 0000aaaa 0",
                        c, rsp_valid, rsp_id, rsp_result, rsp_zero);
      end
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL stall_ready: cyc %0d r0=%b r1=%b busy=%b, required 0 0 1",
                        c, req0_ready, req1_ready, busy);
      end
      @(negedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release: busy=%b r1=%b, required 0 1", busy, req1_ready);
    end
    @(posedge clk);
    sb.push_back('{id: 1'b1, res: 32'h0F00_0F00, zero: 1'b0});
    $display("accept port=1 a=ff00ff00 b=0ff00ff0 (AND)");
    #1 req1_valid = 0;
    @(negedge clk);
    wait_drain();
  endtask

  task automatic test_reset_exec();
    issue(1'b0, 2'b00, 3'b010, 1'b0, 32'h1234, 32'h1111, 32'h2345);
    #1 rst = 1;
    sb.delete();
    #1;
    total++;
    if ({busy, rsp_valid, rsp_id, rsp_zero} !== 4'b0000 || alu_a !== 0 || alu_b !== 0 || alu_aluOp !== 0 || rsp_result !== 0) begin
      bad++; $display("FAIL rst_exec: busy=%b rsp_valid=%b alu_a=%h alu_b=%h rsp_result=%h, required all 0",
                      busy, rsp_valid, alu_a, alu_b, rsp_result);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL rst_exec_ready: got %b while rst high, required 00", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL rst_exec_ghost: rsp_valid=%b after reset, required 0", rsp_valid);
      end
      @(negedge clk);
    end
    req0_valid = 1; req0_aluOp = 2'b11; req0_funct3 = 3'b000; req0_funct7 = 0; req0_a = 32'h55; req0_b = 32'hABC0_0000;
    req1_valid = 1; req1_aluOp = 2'b11; req1_funct3 = 3'b000; req1_funct7 = 0; req1_a = 32'h66; req1_b = 32'h7;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL rst_exec_tie: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    sb.push_back('{id: 1'b0, res: 32'hABC0_0000, zero: 1'b0});
    $display("accept port=0 upper-imm b=abc00000");
    #1 req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    wait_drain();
  endtask

  task automatic test_dropped_valid();
    bit seen = 1'b0;
    rsp_ready = 0;
    issue(1'b0, 2'b10, 3'b000, 1'b0, 32'd100, 32'd40, 32'd60);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (rsp_valid === 1'b1);
    end
    req1_valid = 1; req1_aluOp = 2'b01; req1_funct3 = 3'b110; req1_funct7 = 0; req1_a = 1; req1_b = 2;
    #1;
    total++;
    if (!seen || req1_ready !== 1'b0) begin
      bad++; $display("FAIL drop_pulse: rsp_seen=%b r1=%b during RESP, required 1 0", seen, req1_ready);
    end
    @(negedge clk);
    req1_valid = 0;
    rsp_ready = 1;
    wait_drain();
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL drop_ghost: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rsp_ready = 1;
    req0_valid = 0; req0_aluOp = 0; req0_funct3 = 0; req0_funct7 = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_aluOp = 0; req1_funct3 = 0; req1_funct7 = 0; req1_a = 0; req1_b = 0;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_stall();
    test_reset_exec();
    test_dropped_valid();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL final_queue: %0d outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
